ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; RAM_DEPTH, default 512, words in attached RAM; FIFO_DEPTH, default 4, output buffer entries (power of two, >=2); AW = clog2(RAM_DEPTH).
REQ-002 clkIn  input  1  clock; all state updates on rising edge.
REQ-003 rstIn  input  1  reset, asynchronous, active-high.
REQ-004 startIn  input  1  one-cycle job request; baseAddrIn and lenIn sampled on the same cycle.
REQ-005 baseAddrIn  input  AW  first RAM word address.
REQ-006 lenIn  input  AW+1  number of words to read, 0..RAM_DEPTH.
REQ-007 busyOut  output  1  high from the cycle after an accepted start until doneOut.
REQ-008 doneOut  output  1  one-cycle pulse when the last word of a job leaves the stream.
REQ-009 ramAddrOut  output  AW  read address to RAM port.
REQ-010 ramRdEnOut  output  1  read request to RAM port; RAM returns data and ack exactly one cycle later.
REQ-011 ramRdDataIn  input  DATA_WIDTH  RAM read data.
REQ-012 ramRdAckIn  input  1  RAM read acknowledge, qualifies ramRdDataIn.
REQ-013 dataOut  output  DATA_WIDTH  stream data, FIFO head.
REQ-014 validOut  output  1  stream valid; high whenever FIFO non-empty.
REQ-015 readyIn  input  1  stream ready; transfer when validOut and readyIn high.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN.
REQ-017 IDLE: startIn with lenIn>0 -> READ, address counter = baseAddrIn, issue counter = lenIn; startIn with lenIn=0 -> stay IDLE, doneOut pulse next cycle, no RAM read.
REQ-018 startIn outside IDLE SHALL be ignored (no parameter capture, no effect on current job).
REQ-019 READ: ramRdEnOut asserted in a cycle iff issue counter>0 and (FIFO count + in-flight reads) < FIFO_DEPTH; ramAddrOut = address counter, combinationally.
REQ-020 Each issued read SHALL increment address counter modulo RAM_DEPTH (wrap RAM_DEPTH-1 -> 0) and decrement issue counter.
REQ-021 In-flight counter (0..1 given one-cycle RAM latency, sized for 2) SHALL increment on issue, decrement on ramRdAckIn; both same cycle -> unchanged.
REQ-022 ramRdAckIn SHALL push ramRdDataIn into FIFO; credit rule of REQ-019 guarantees no overflow; push to full FIFO SHALL never occur.
REQ-023 Simultaneous push and pop SHALL leave FIFO count unchanged; push to empty FIFO visible at validOut next cycle (no fall-through).
REQ-024 READ -> DRAIN when last read issued; DRAIN -> IDLE when in-flight=0, FIFO empty after final pop; doneOut pulses the cycle after final word transfers.
REQ-025 Peak throughput SHALL be one word per cycle with readyIn held high; startup latency start -> first validOut = 3 cycles.
REQ-026 readyIn low SHALL stall issue via credit; dataOut stable while validOut high and readyIn low.
REQ-027 lenIn=RAM_DEPTH SHALL read every word once, wrapping at most once.

Reset
REQ-028 rstIn high SHALL immediately: FSM IDLE, counters 0, FIFO empty, validOut=0, busyOut=0, doneOut=0, ramRdEnOut=0, ramAddrOut=0.
REQ-029 Reset mid-job SHALL discard all buffered and in-flight data; acks arriving after reset release SHALL be ignored while in-flight=0 in IDLE.

Configuration
REQ-030 Macro RAM_STREAM_READER_LAST_EN SHALL add output lastOut (1 bit), high with validOut on the final word of a job, stored per FIFO entry.
REQ-031 Without RAM_STREAM_READER_LAST_EN, port lastOut and its FIFO storage SHALL not exist; all other behaviour identical.

Verification
REQ-032 base=10, len=4, readyIn=1 -> ramAddrOut 10,11,12,13 on consecutive cycles; dataOut RAM[10..13] in order; doneOut one pulse; busy low after.
REQ-033 base=RAM_DEPTH-2, len=4 -> addresses 510,511,0,1 (default params); data order preserved.
REQ-034 len=8, readyIn low 10 cycles after first valid -> at most FIFO_DEPTH reads issued, no data lost or duplicated after readyIn high.
REQ-035 len=0 -> doneOut pulse next cycle, ramRdEnOut never high, validOut never high.
REQ-036 rstIn pulse during READ with FIFO half full -> all outputs at reset values immediately; new job base=0,len=2 afterwards returns only RAM[0],RAM[1].
REQ-037 With RAM_STREAM_READER_LAST_EN, len=3 -> lastOut high only on third transfer; startIn during job ignored.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a block of words from a one-cycle-latency RAM port and streams them out through a small credit-managed FIFO.
// Define RAM_STREAM_READER_LAST_EN to add lastOut, which flags the final word of each job.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(RAM_DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [AW-1:0]         baseAddrIn,
  input  logic [AW:0]           lenIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [AW-1:0]         ramAddrOut,
  output logic                  ramRdEnOut,
  input  logic [DATA_WIDTH-1:0] ramRdDataIn,
  input  logic                  ramRdAckIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
`ifdef RAM_STREAM_READER_LAST_EN
  output logic                  lastOut,
`endif
  input  logic                  readyIn
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [AW-1:0] ADDR_MAX  = AW'(RAM_DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(1'b0);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT                 stateR;
  stateT                 stateNextS;
  logic [AW-1:0]         addrR;
  logic [AW:0]           issueR;
  logic [1:0]            inflightR;
  logic [CW-1:0]         countR;
  logic [PW-1:0]         wrPtrR;
  logic [PW-1:0]         rdPtrR;
  logic [DATA_WIDTH-1:0] dataMemR [FIFO_DEPTH];
  logic                  doneR;
  logic                  acceptS;
  logic                  emptyJobS;
  logic                  issueS;
  logic                  finishS;
  logic                  pushS;
  logic                  popS;
  logic [CW:0]           creditUsedS;
`ifdef RAM_STREAM_READER_LAST_EN
  logic                  lastMemR [FIFO_DEPTH];
  logic [AW:0]           pushLeftR;
`endif

  // Acks are only honoured against an outstanding read, so stale acks after a reset are dropped.
  assign pushS       = ramRdAckIn && (inflightR != 2'd0);
  assign popS        = validOut && readyIn;
  assign creditUsedS = (CW+1)'(countR) + (CW+1)'(inflightR);

  assign busyOut    = (stateR != IDLE);
  assign doneOut    = doneR;
  assign ramAddrOut = addrR;
  assign ramRdEnOut = issueS;
  assign validOut   = (countR != CW'(1'b0));
  assign dataOut    = dataMemR[rdPtrR];
`ifdef RAM_STREAM_READER_LAST_EN
  assign lastOut    = lastMemR[rdPtrR];
`endif

  // State register.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state decode and per-cycle job strobes.
  always_comb begin
    stateNextS = stateR;
    acceptS    = 1'b0;
    emptyJobS  = 1'b0;
    issueS     = 1'b0;
    finishS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (startIn) begin
          if (lenIn == LEN_ZERO) begin
            emptyJobS = 1'b1;
          end else begin
            acceptS    = 1'b1;
            stateNextS = READ;
          end
        end else begin
          stateNextS = IDLE;
        end
      end
      READ: begin
        // Credit counts both buffered words and reads still in flight.
        issueS = (issueR != LEN_ZERO) && (creditUsedS < {1'b0, FIFO_FULL});
        if (issueS && (issueR == LEN_ONE)) begin
          stateNextS = DRAIN;
        end else begin
          stateNextS = READ;
        end
      end
      DRAIN: begin
        finishS = popS && !pushS && (countR == CNT_ONE) && (inflightR == 2'd0);
        if (finishS) begin
          stateNextS = IDLE;
        end else begin
          stateNextS = DRAIN;
        end
      end
      default: begin
        stateNextS = IDLE;
      end
    endcase
  end

  // Address/issue counters, in-flight tracking and the done pulse.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      addrR     <= ADDR_ZERO;
      issueR    <= LEN_ZERO;
      inflightR <= 2'd0;
      doneR     <= 1'b0;
    end else begin
      doneR <= emptyJobS || finishS;
      if (acceptS) begin
        addrR  <= baseAddrIn;
        issueR <= lenIn;
      end else if (issueS) begin
        addrR  <= (addrR == ADDR_MAX) ? ADDR_ZERO : (addrR + ADDR_ONE);
        issueR <= issueR - LEN_ONE;
      end else begin
        addrR  <= addrR;
        issueR <= issueR;
      end
      case ({issueS, pushS})
        2'b10:   inflightR <= inflightR + 2'd1;
        2'b01:   inflightR <= inflightR - 2'd1;
        default: inflightR <= inflightR;
      endcase
    end
  end

  // Output FIFO: registered head, no fall-through.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      countR <= CW'(1'b0);
      wrPtrR <= PW'(1'b0);
      rdPtrR <= PW'(1'b0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dataMemR[i] <= DATA_WIDTH'(1'b0);
      end
    end else begin
      if (pushS) begin
        dataMemR[wrPtrR] <= ramRdDataIn;
        wrPtrR           <= wrPtrR + PTR_ONE;
      end else begin
        wrPtrR <= wrPtrR;
      end
      if (popS) begin
        rdPtrR <= rdPtrR + PTR_ONE;
      end else begin
        rdPtrR <= rdPtrR;
      end
      case ({pushS, popS})
        2'b10:   countR <= countR + CNT_ONE;
        2'b01:   countR <= countR - CNT_ONE;
        default: countR <= countR;
      endcase
    end
  end

`ifdef RAM_STREAM_READER_LAST_EN
  // Per-entry last flag, derived from the number of words still to arrive.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      pushLeftR <= LEN_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        lastMemR[i] <= 1'b0;
      end
    end else begin
      if (acceptS) begin
        pushLeftR <= lenIn;
      end else if (pushS) begin
        pushLeftR <= pushLeftR - LEN_ONE;
      end else begin
        pushLeftR <= pushLeftR;
      end
      if (pushS) begin
        lastMemR[wrPtrR] <= (pushLeftR == LEN_ONE);
      end
    end
  end
`endif

endmodule
